// File: rtl/fifo_wr_ingress_if.sv
// Producer / FIFO-write-port bundle for the write-domain ingress stage.
`timescale 1ns/1ps
interface fifo_wr_ingress_if #(
    parameter int D_WIDTH = 8
);
    logic [D_WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               w_full;
    logic               w_inc;
    logic [D_WIDTH-1:0] w_data;

    modport slave (
        input  in_data, in_valid, w_full,
        output in_ready, w_inc, w_data
    );

    modport master (
        output in_data, in_valid, w_full,
        input  in_ready, w_inc, w_data
    );
endinterface

// File: rtl/fifo_wr_ingress.sv
// Write-domain ingress: 2-entry skid buffer in front of the async FIFO write port,
// with a wrapping write-word counter and a sticky back-pressure stall flag.
`timescale 1ns/1ps
module fifo_wr_ingress #(
    parameter int D_WIDTH     = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int STALL_LIMIT = 8
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    fifo_wr_ingress_if.slave     bus,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic                 stall_flag,
    input  logic                 stall_clr
);
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t               r_state;
    logic [D_WIDTH-1:0]   r_head;
    logic [D_WIDTH-1:0]   r_skid;
    logic [CNT_WIDTH-1:0] r_wr_count;
    logic [SC_W-1:0]      r_stall_cnt;
    logic                 r_stall_flag;

    logic w_accept;
    logic w_drain;
    logic w_blocked;
    logic w_stall_set;

    // in_ready depends on state only, so the producer never sees a path from w_full.
    assign bus.in_ready = (r_state != TWO);
    assign bus.w_inc    = (r_state != EMPTY) & ~bus.w_full;
    assign bus.w_data   = r_head;

    assign w_accept    = bus.in_valid & bus.in_ready;
    assign w_drain     = bus.w_inc;
    assign w_blocked   = (r_state != EMPTY) & bus.w_full;
    assign w_stall_set = w_blocked & (r_stall_cnt == SC_W'(STALL_LIMIT - 1));

    assign wr_count   = r_wr_count;
    assign stall_flag = r_stall_flag;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= ONE;
                        r_head  <= bus.in_data;
                    end
                end
                ONE: begin
                    if (w_accept && !w_drain) begin
                        r_state <= TWO;
                        r_skid  <= bus.in_data;
                    end else if (!w_accept && w_drain) begin
                        r_state <= EMPTY;
                    end else if (w_accept && w_drain) begin
                        r_head  <= bus.in_data;
                    end
                end
                TWO: begin
                    if (w_drain) begin
                        r_state <= ONE;
                        r_head  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_count <= '0;
        end else if (w_drain) begin
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
        end
    end

    // Counter saturates at the limit; the flag fires only on the edge it gets there.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_stall_cnt  <= '0;
            r_stall_flag <= 1'b0;
        end else begin
            if (!w_blocked) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != SC_W'(STALL_LIMIT)) begin
                r_stall_cnt <= r_stall_cnt + SC_W'(1);
            end

            if (w_stall_set) begin
                r_stall_flag <= 1'b1;
            end else if (stall_clr) begin
                r_stall_flag <= 1'b0;
            end
        end
    end
endmodule
